// File: rtl/snake_ctrl_pkg.sv
// Shared definitions for the snake direction scheduler: direction codes,
// FSM state encoding and the opposite-direction helper.
package snake_ctrl_pkg;

   localparam logic [2:0] DIR_NONE  = 3'b000;
   localparam logic [2:0] DIR_UP    = 3'b001;
   localparam logic [2:0] DIR_DOWN  = 3'b010;
   localparam logic [2:0] DIR_LEFT  = 3'b011;
   localparam logic [2:0] DIR_RIGHT = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_HALT  = 2'b11
   } state_e;

   // True when a and b are the two halves of an opposite pair.
   function automatic logic is_opposite(input logic [2:0] a, input logic [2:0] b);
      logic r;
      case ({a, b})
         6'b001_010: r = 1'b1;
         6'b010_001: r = 1'b1;
         6'b011_100: r = 1'b1;
         6'b100_011: r = 1'b1;
         default:    r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dir_cmd_fifo.sv
// Small synchronous FIFO holding pending 3-bit direction commands.
// Pointers carry one extra bit so full and empty are distinguishable.
module dir_cmd_fifo
   import snake_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_push,
   input  logic       i_pop,
   input  logic       i_flush,
   input  logic [2:0] i_din,
   output logic [2:0] o_dout,
   output logic       o_full,
   output logic       o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  r_wptr;
   logic [AW:0]  r_rptr;
   logic [2:0]   r_mem [DEPTH];
   logic         w_do_pop;
   logic         w_do_push;

   assign o_empty   = (r_wptr == r_rptr);
   assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   // A pop on an empty queue is ignored; a push into a full queue only
   // succeeds when a pop frees a slot in the same cycle.
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_dout    = r_mem[r_rptr[AW-1:0]];

   // Pointer update; flush empties the queue and overrides push/pop.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (i_flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
         if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
      end
   end

   // Storage write.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= DIR_NONE;
      end else if (w_do_push && !i_flush) begin
         r_mem[r_wptr[AW-1:0]] <= i_din;
      end
   end

endmodule

// File: rtl/snake_dir_scheduler.sv
// Game-step scheduler: captures button edges into a command queue, applies at
// most one legal direction change per step and drives the control mux.
module snake_dir_scheduler
   import snake_ctrl_pkg::*;
#(
   parameter int TICK_DIV   = 25_000_000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_btn_up,
   input  logic       i_btn_down,
   input  logic       i_btn_left,
   input  logic       i_btn_right,
   input  logic       i_btn_pause,
   input  logic       i_game_over,
   output logic       o_sel,
   output logic [2:0] o_ctrl,
   output logic [2:0] o_cur_dir,
   output logic       o_tick,
   output logic       o_q_full,
   output logic       o_overflow
);

   localparam int              CW     = $clog2(TICK_DIV);
   localparam logic [CW-1:0]   C_TMAX = CW'(TICK_DIV - 1);

   state_e        r_state;
   state_e        w_state_nxt;
   logic [4:0]    r_btn;
   logic [4:0]    r_btn_prev;
   logic [4:0]    w_edge;
   logic [2:0]    w_dir;
   logic          w_dir_vld;
   logic [CW-1:0] r_cnt;
   logic          w_tick;
   logic          w_step;
   logic          w_push;
   logic          w_pop;
   logic          w_flush;
   logic          w_full;
   logic          w_empty;
   logic [2:0]    w_fifo_dout;
   logic [2:0]    w_dir_nxt;
   logic          r_sel;
   logic [2:0]    r_ctrl;
   logic [2:0]    r_cur_dir;
   logic          r_overflow;

   // Button sampling: current and previous registered levels for edge detect.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_btn      <= 5'b00000;
         r_btn_prev <= 5'b00000;
      end else begin
         r_btn      <= {i_btn_pause, i_btn_right, i_btn_left, i_btn_down, i_btn_up};
         r_btn_prev <= r_btn;
      end
   end

   assign w_edge = r_btn & ~r_btn_prev;

   // Priority pick among simultaneous direction edges: UP > DOWN > LEFT > RIGHT.
   always_comb begin
      w_dir     = DIR_NONE;
      w_dir_vld = 1'b1;
      if (w_edge[0])      w_dir = DIR_UP;
      else if (w_edge[1]) w_dir = DIR_DOWN;
      else if (w_edge[2]) w_dir = DIR_LEFT;
      else if (w_edge[3]) w_dir = DIR_RIGHT;
      else                w_dir_vld = 1'b0;
   end

   assign w_tick  = (r_state == ST_RUN) && (r_cnt == C_TMAX);
   assign w_step  = w_tick & ~i_game_over;
   assign w_push  = w_dir_vld & ~i_game_over & ((r_state == ST_IDLE) || (r_state == ST_RUN));
   assign w_pop   = w_step & ~w_empty;
   assign w_flush = (r_state == ST_HALT) | i_game_over;

   dir_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_din   (w_dir),
      .o_dout  (w_fifo_dout),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // FSM next state; game_over forces HALT from anywhere.
   always_comb begin
      w_state_nxt = r_state;
      if (i_game_over) begin
         w_state_nxt = ST_HALT;
      end else begin
         case (r_state)
            ST_IDLE:  w_state_nxt = w_dir_vld ? ST_RUN : ST_IDLE;
            ST_RUN:   w_state_nxt = w_edge[4] ? ST_PAUSE : ST_RUN;
            ST_PAUSE: w_state_nxt = w_edge[4] ? ST_RUN : ST_PAUSE;
            ST_HALT:  w_state_nxt = ST_HALT;
            default:  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Step counter: runs in RUN, frozen in PAUSE, cleared otherwise.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_game_over) begin
         r_cnt <= '0;
      end else begin
         case (r_state)
            ST_RUN:   r_cnt <= (r_cnt == C_TMAX) ? '0 : r_cnt + CW'(1);
            ST_PAUSE: r_cnt <= r_cnt;
            default:  r_cnt <= '0;
         endcase
      end
   end

   // Direction chosen at this step: the popped entry unless it is a no-op or a reversal.
   always_comb begin
      w_dir_nxt = r_cur_dir;
      if (w_pop && (w_fifo_dout != DIR_NONE) && (w_fifo_dout != r_cur_dir) &&
          !is_opposite(w_fifo_dout, r_cur_dir)) begin
         w_dir_nxt = w_fifo_dout;
      end else begin
         w_dir_nxt = r_cur_dir;
      end
   end

   // Output registers: one sel pulse per step with ctrl already holding the new direction.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sel     <= 1'b0;
         r_ctrl    <= DIR_NONE;
         r_cur_dir <= DIR_RIGHT;
      end else begin
         r_sel <= w_step;
         if (w_step) begin
            r_ctrl    <= w_dir_nxt;
            r_cur_dir <= w_dir_nxt;
         end
      end
   end

   // Sticky overflow: a push was dropped because the queue was full.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                         r_overflow <= 1'b0;
      else if (w_push && w_full && !w_pop)  r_overflow <= 1'b1;
   end

   assign o_sel      = r_sel;
   assign o_ctrl     = r_ctrl;
   assign o_cur_dir  = r_cur_dir;
   assign o_tick     = w_tick;
   assign o_q_full   = w_full;
   assign o_overflow = r_overflow;

endmodule

// File: tb/tb_snake_dir_scheduler.sv
// Directed bench for snake_dir_scheduler with TICK_DIV=4, FIFO_DEPTH=4.
module tb_snake_dir_scheduler;
   import snake_ctrl_pkg::*;

   localparam logic [4:0] M_UP = 5'b00001;
   localparam logic [4:0] M_DN = 5'b00010;
   localparam logic [4:0] M_LF = 5'b00100;
   localparam logic [4:0] M_RT = 5'b01000;
   localparam logic [4:0] M_PS = 5'b10000;

   typedef struct {
      logic [4:0] btn;
      logic [2:0] exp_dir;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       b_up = 1'b0, b_dn = 1'b0, b_lf = 1'b0, b_rt = 1'b0, b_ps = 1'b0;
   logic       game_over = 1'b0;
   logic       o_sel, o_tick, o_q_full, o_overflow;
   logic [2:0] o_ctrl, o_cur_dir;

   int n_chk = 0;
   int n_pass = 0;

   snake_dir_scheduler #(.TICK_DIV(4), .FIFO_DEPTH(4)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_btn_up    (b_up),
      .i_btn_down  (b_dn),
      .i_btn_left  (b_lf),
      .i_btn_right (b_rt),
      .i_btn_pause (b_ps),
      .i_game_over (game_over),
      .o_sel       (o_sel),
      .o_ctrl      (o_ctrl),
      .o_cur_dir   (o_cur_dir),
      .o_tick      (o_tick),
      .o_q_full    (o_q_full),
      .o_overflow  (o_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic drive(input logic [4:0] m);
      {b_ps, b_rt, b_lf, b_dn, b_up} = m;
   endtask

   // Hold the mask for one clock, then release; call and return on a negedge.
   task automatic press(input logic [4:0] m);
      drive(m);
      @(negedge clk);
      drive(5'b00000);
   endtask

   task automatic wait_tick(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!o_tick && cyc < 40);
      if (!o_tick) cyc = -1;
   endtask

   task automatic step_check(input string nm, input logic [2:0] exp, input int exp_cyc);
      int c;
      wait_tick(c);
      check({nm, " tick latency"}, c, exp_cyc);
      @(negedge clk);
      check({nm, " sel"}, int'(o_sel), 1);
      check({nm, " ctrl"}, int'(o_ctrl), int'(exp));
      check({nm, " cur_dir"}, int'(o_cur_dir), int'(exp));
   endtask

   vec_t vecs[10];
   logic [4:0] fill_seq[6];

   initial begin
      int c;
      logic bad;

      vecs[0] = '{M_DN, DIR_UP};
      vecs[1] = '{M_UP, DIR_UP};
      vecs[2] = '{M_LF, DIR_LEFT};
      vecs[3] = '{M_RT, DIR_LEFT};
      vecs[4] = '{M_UP | M_DN | M_LF | M_RT, DIR_UP};
      vecs[5] = '{M_DN | M_RT, DIR_UP};
      vecs[6] = '{M_LF | M_RT, DIR_LEFT};
      vecs[7] = '{5'b00000, DIR_LEFT};
      vecs[8] = '{M_DN | M_LF | M_RT, DIR_DOWN};
      vecs[9] = '{M_RT, DIR_RIGHT};
      fill_seq = '{M_UP, M_LF, M_DN, M_RT, M_UP, M_LF};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("reset sel", int'(o_sel), 0);
      check("reset ctrl", int'(o_ctrl), 0);
      check("reset cur_dir", int'(o_cur_dir), 4);
      check("reset tick", int'(o_tick), 0);
      check("reset q_full", int'(o_q_full), 0);
      check("reset overflow", int'(o_overflow), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // First press from IDLE
      press(M_UP);
      step_check("first up", DIR_UP, 4);

      // Table of single-step vectors
      for (int i = 0; i < 10; i++) begin
         press(vecs[i].btn);
         check($sformatf("vec%0d sel low", i), int'(o_sel), 0);
         step_check($sformatf("vec%0d", i), vecs[i].exp_dir, 2);
      end

      // LEFT (reversal of RIGHT) then UP within one step
      press(M_LF);
      press(M_UP);
      wait_tick(c);
      check("left-up tick latency", c, 1);
      @(negedge clk);
      check("left discarded sel", int'(o_sel), 1);
      check("left discarded ctrl", int'(o_ctrl), int'(DIR_RIGHT));
      step_check("up applied", DIR_UP, 3);

      // UP and LEFT in the same cycle: only UP queued
      press(M_UP | M_LF);
      step_check("same-cycle step1", DIR_UP, 2);
      step_check("same-cycle step2", DIR_UP, 3);

      // Pause mid-count, presses dropped, resume with remaining counts
      press(M_PS);
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (o_tick || o_sel) bad = 1'b1;
         if (i == 5) drive(M_LF);
         if (i == 6) drive(5'b00000);
      end
      check("pause no tick/sel", int'(bad), 0);
      check("pause overflow", int'(o_overflow), 0);
      press(M_PS);
      step_check("resume", DIR_UP, 2);

      // Asynchronous reset during a sel pulse
      rst_n = 1'b0;
      #1;
      check("rst-in-sel sel", int'(o_sel), 0);
      check("rst-in-sel ctrl", int'(o_ctrl), 0);
      check("rst-in-sel cur_dir", int'(o_cur_dir), 4);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Queue fill: full after 4, push+pop at full, then dropped push
      for (int k = 0; k < 6; k++) begin
         drive(fill_seq[k]);
         @(negedge clk);
         if (k == 3) check("fill 3 entries q_full", int'(o_q_full), 0);
         if (k == 4) begin
            check("fill 4 entries q_full", int'(o_q_full), 1);
            check("fill tick", int'(o_tick), 1);
            check("fill overflow before", int'(o_overflow), 0);
         end
         if (k == 5) begin
            check("push+pop full overflow", int'(o_overflow), 0);
            check("push+pop full q_full", int'(o_q_full), 1);
            check("fill step1 sel", int'(o_sel), 1);
            check("fill step1 ctrl", int'(o_ctrl), int'(DIR_UP));
         end
      end
      drive(5'b00000);
      @(negedge clk);
      check("dropped push overflow", int'(o_overflow), 1);
      step_check("drain LEFT", DIR_LEFT, 2);
      step_check("drain DOWN", DIR_DOWN, 3);
      step_check("drain RIGHT", DIR_RIGHT, 3);
      step_check("drain UP", DIR_UP, 3);
      step_check("drain empty", DIR_UP, 3);

      // game_over coincident with tick
      press(M_LF);
      wait_tick(c);
      check("halt tick latency", c, 2);
      game_over = 1'b1;
      @(negedge clk);
      check("halt state", int'(dut.r_state), int'(ST_HALT));
      check("halt no sel", int'(o_sel), 0);
      check("halt cur_dir", int'(o_cur_dir), int'(DIR_UP));
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (o_sel || o_tick) bad = 1'b1;
      end
      check("halt quiet", int'(bad), 0);
      check("halt queue empty", int'(dut.u_fifo.o_empty), 1);
      check("halt q_full", int'(o_q_full), 0);
      rst_n = 1'b0;
      game_over = 1'b0;
      #1;
      check("halt reset ctrl", int'(o_ctrl), 0);
      check("halt reset cur_dir", int'(o_cur_dir), 4);
      check("halt reset overflow", int'(o_overflow), 0);
      check("halt reset sel", int'(o_sel), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/snake_dir_scheduler.md
# snake_dir_scheduler

Sequences the 3-bit direction control word into `control_signal_mux` for the snake game. It captures debounced button presses into a small command queue and applies at most one legal direction change per game step. On every step it drives the mux `in` with the current direction code and pulses `select` for one cycle. It also owns the game-step timebase and the run/pause/halt sequencing.

## Interface
- `TICK_DIV`, default 25_000_000: clocks per game step; minimum 2.
- `FIFO_DEPTH`, default 4: command queue entries; power of two, minimum 2.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: debounced level inputs.
- `btn_pause` in 1: debounced level input; each rising edge toggles pause.
- `game_over` in 1: level input from collision logic.
- `sel` out 1: drives mux `select`; one-cycle pulse per step.
- `ctrl` out 3: drives mux `in`; holds the direction code.
- `cur_dir` out 3: currently applied direction.
- `tick` out 1: one-cycle game-step strobe.
- `q_full` out 1: command queue is full.
- `overflow` out 1: sticky flag; set when a command is dropped because the queue is full.

## Operation
- Direction codes:
  - `NONE` = 000, `UP` = 001, `DOWN` = 010, `LEFT` = 011, `RIGHT` = 100.
  - `UP`/`DOWN` and `LEFT`/`RIGHT` are opposite pairs.
- Button edges:
  - Every button input is registered once; an edge is current high and previous low.
  - Multiple direction edges in the same cycle: priority is UP > DOWN > LEFT > RIGHT. Only the winner is offered to the queue; the rest are discarded.
- FSM states: `IDLE`, `RUN`, `PAUSE`, `HALT`.
  - `IDLE`: a direction edge enqueues the command, clears the step counter and moves to `RUN`. Pause edges are ignored.
  - `RUN`: the step counter counts 0..`TICK_DIV`-1. `tick`=1 in the cycle the counter is at `TICK_DIV`-1, and the counter wraps to 0. Direction edges enqueue. A pause edge moves to `PAUSE`.
  - `PAUSE`: the counter is frozen. Direction edges are dropped without being enqueued and without setting `overflow`. A pause edge returns to `RUN` and the counter resumes from its frozen value.
  - `HALT`: entered from any state when `game_over`=1. The queue is flushed, the counter is cleared and `sel`/`tick` are held at 0. The only exit is reset.
- Step action on `tick` in `RUN`:
  - Pop one queue entry if the queue is non-empty.
  - If the entry is the opposite of `cur_dir` or equal to it, discard it and leave `cur_dir` unchanged. Otherwise `cur_dir` takes the entry.
  - Only one pop per tick; a discarded entry is not followed by a second pop.
  - Empty queue: `cur_dir` is unchanged, but the step still emits (the snake keeps moving).
- Queue behaviour:
  - A push while full is dropped and sets `overflow`.
  - A push and pop in the same cycle while full: both succeed and `overflow` is not set.
  - A push and pop in the same cycle while empty: the pop sees empty; the push is stored for the next tick.
- `game_over` and `tick` in the same cycle: `HALT` wins; no `sel` pulse follows.

## Timing
- Reset values:
  - `sel`=0, `ctrl`=000, `cur_dir`=100 (`RIGHT`), `tick`=0, `q_full`=0, `overflow`=0.
  - State `IDLE`, counter 0, queue empty.
- Step latency:
  - `tick` is high in cycle T.
  - `cur_dir` updates at the end of T.
  - `ctrl`=new `cur_dir` and `sel`=1 in cycle T+1; `sel`=0 at T+2.
  - `ctrl` holds its value between pulses, so it is stable for the whole `sel` cycle.
- Button latency: button rising at cycle B produces a queue write at the end of B+1; the entry is visible to a tick at B+2 or later.
- With `TICK_DIV`=N, `tick` has period N clocks in uninterrupted `RUN`.
- Reset mid-step, including during a `sel` pulse: all outputs return to reset values asynchronously.

## Structure
- Shared package `snake_ctrl_pkg`:
  - Direction code constants and state encoding.
  - `is_opposite` function.
- Sub-module `dir_cmd_fifo`:
  - Parameterised synchronous FIFO, 3-bit wide, `FIFO_DEPTH` entries.
  - Pointers one bit wider than the address.
  - Ports: push, pop, flush, full, empty, dout.
- Top level: edge detect, priority pick, step counter, FSM, output registers.

## Test plan
All scenarios use `TICK_DIV`=4 and `FIFO_DEPTH`=4.
- Reset, then pulse `btn_up` → state `RUN`; first `tick` 4 cycles after entry; next cycle `sel`=1, `ctrl`=001, `cur_dir`=001.
- From `cur_dir`=`RIGHT`, press `LEFT` then `UP` within one step → `LEFT` is discarded at the first tick (`ctrl` stays 100); `UP` is applied at the second tick (`ctrl`=001).
- `btn_up` and `btn_left` rise in the same cycle → only `UP` is enqueued; the queue count increments by 1.
- Five distinct presses with no tick between them → `q_full`=1 after the fourth; the fifth sets `overflow`=1; four entries are retained.
- Pause edge mid-count → no `tick`/`sel` for 20 cycles and presses are not enqueued; a second pause edge resumes, with `tick` arriving after the remaining counts.
- `game_over` coincident with `tick` → state `HALT`; `sel` stays 0 forever and the queue is empty; `rst_n` low restores `ctrl`=000, `cur_dir`=100.
